// File: rtl/hm_sha_pkg.sv
// hm_sha_pkg: shared widths, block types and padder state encoding for the SHA message padder.
package hm_sha_pkg;
  localparam int SHA_BLOCK_WORDS = 16;
  localparam int SHA_LEN_WORD_HI = 14;
  typedef logic [31:0] word_t;
  typedef word_t [SHA_BLOCK_WORDS-1:0] block_t;
  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_PAD, ST_LEN, ST_EMIT} pad_state_e;
  localparam word_t PAD_FULL = 32'h8000_0000;
endpackage

// File: rtl/hm_sha_pad_word.sv
// hm_sha_pad_word: zeroes the invalid bytes of a partial last word and inserts the 0x80 pad byte.
module hm_sha_pad_word
  import hm_sha_pkg::*;
(
  input  word_t      word,
  input  logic [1:0] nbytes,
  output word_t      padded
);
  assign padded = nbytes == 2'd1 ? {word[31:24], 24'h80_0000} :
                  nbytes == 2'd2 ? {word[31:16], 16'h8000} :
                  nbytes == 2'd3 ? {word[31:8], 8'h80} : word;
endmodule

// File: rtl/sha_msg_padder.sv
// sha_msg_padder: packs a word stream into SHA-256 512-bit blocks with padding and bit length.
// Define HM_PADDER_BSWAP_EN to byte-reverse in_data on entry (little-endian source).
module sha_msg_padder
  import hm_sha_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  word_t      in_data,
  input  logic       in_last,
  input  logic [1:0] in_nbytes,
  output logic       blk_valid,
  input  logic       blk_ready,
  output block_t     blk_data,
  output logic       blk_first,
  output logic       blk_last
);
  pad_state_e  state, state_nx;
  block_t      blk_q;
  logic [3:0]  idx;
  logic [60:0] bytes;
  logic [1:0]  nb_q;
  logic        pad_pend, len_pend, first_q, last_q;
  word_t       data_in, pad_w;
  logic [63:0] bitlen;
  logic [4:0]  p;
  logic        acc, hs;
`ifdef HM_PADDER_BSWAP_EN
  assign data_in = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign data_in = in_data;
`endif
  assign bitlen = {bytes, 3'b000};
  // a partial last word carries its own 0x80, a full one pushes it to the next slot
  assign p = nb_q != 2'd0 ? {1'b0, idx} : {1'b0, idx} + 5'd1;
  assign acc = in_valid && in_ready;
  assign hs = blk_valid && blk_ready;
  assign blk_data = blk_q;
  assign blk_first = blk_valid && first_q;
  assign blk_last = blk_valid && last_q;

  hm_sha_pad_word u_pad (.word(blk_q[idx]), .nbytes(nb_q), .padded(pad_w));

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= ST_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    in_ready = state == ST_IDLE || state == ST_FILL;
    blk_valid = state == ST_EMIT;
    case (state)
      ST_IDLE, ST_FILL: if (acc) state_nx = in_last ? ST_PAD : idx == 4'd15 ? ST_EMIT : ST_FILL;
      ST_PAD, ST_LEN:   state_nx = ST_EMIT;
      ST_EMIT:          if (hs) state_nx = len_pend ? ST_LEN : last_q ? ST_IDLE : ST_FILL;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      blk_q <= '0;
      idx <= '0;
      bytes <= '0;
      nb_q <= '0;
      pad_pend <= 1'b0;
      len_pend <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_FILL: if (acc) begin
          blk_q[idx] <= data_in;
          bytes <= bytes + (in_last && in_nbytes != 2'd0 ? {59'd0, in_nbytes} : 61'd4);
          nb_q <= in_last ? in_nbytes : 2'd0;
          if (!in_last) idx <= idx + 4'd1;
          if (state == ST_IDLE) first_q <= 1'b1;
        end
        ST_PAD: begin
          if (nb_q != 2'd0) blk_q[idx] <= pad_w;
          else if (!p[4]) blk_q[p[3:0]] <= PAD_FULL;
          pad_pend <= p[4];
          len_pend <= p > 5'd13;
          last_q <= p <= 5'd13;
          if (p <= 5'd13) begin
            blk_q[SHA_LEN_WORD_HI] <= bitlen[63:32];
            blk_q[SHA_LEN_WORD_HI+1] <= bitlen[31:0];
          end
        end
        ST_LEN: begin
          if (pad_pend) blk_q[0] <= PAD_FULL;
          blk_q[SHA_LEN_WORD_HI] <= bitlen[63:32];
          blk_q[SHA_LEN_WORD_HI+1] <= bitlen[31:0];
          last_q <= 1'b1;
          pad_pend <= 1'b0;
          len_pend <= 1'b0;
        end
        ST_EMIT: if (hs) begin
          blk_q <= '0;
          idx <= '0;
          first_q <= 1'b0;
          last_q <= 1'b0;
          if (last_q) bytes <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sha_msg_padder.sv
// tb_sha_msg_padder: scoreboard bench; expected blocks come from plain SHA-256 byte-level padding.
module tb_sha_msg_padder;
  import hm_sha_pkg::*;
  logic clk = 0, n_rst = 0, in_valid = 0, in_last = 0;
  logic [1:0] in_nbytes = 0;
  word_t in_data = 0;
  logic in_ready, blk_valid, blk_first, blk_last, blk_ready;
  logic rnd_ready = 0, ready_fix = 0, rnd_bit = 1;
  block_t blk_data;
  typedef struct {block_t d; logic f; logic l;} exp_t;
  exp_t sb[$];
  exp_t got;
  byte unsigned msg[$];
  int checks = 0, fails = 0;

  assign blk_ready = rnd_ready ? rnd_bit : ready_fix;
  always #5 clk = ~clk;

  sha_msg_padder dut (.clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last));

  task automatic chk(string n, logic [511:0] a, logic [511:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic word_t src(word_t w);
`ifdef HM_PADDER_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // standard padding: msg || 0x80 || zeros || 64-bit big-endian bit length
  task automatic model();
    byte unsigned pb[$];
    longint unsigned len;
    int nblk;
    exp_t e;
    pb = msg;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    len = 64'(msg.size()) * 8;
    for (int i = 7; i >= 0; i--) pb.push_back(8'(len >> (8 * i)));
    nblk = pb.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int w = 0; w < 16; w++)
        e.d[w] = {pb[64*b+4*w], pb[64*b+4*w+1], pb[64*b+4*w+2], pb[64*b+4*w+3]};
      e.f = b == 0;
      e.l = b == nblk - 1;
      sb.push_back(e);
    end
  endtask

  task automatic put_word(word_t w, logic last, logic [1:0] nb);
    bit done = 0;
    in_valid = 1; in_data = w; in_last = last; in_nbytes = nb;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    if (!done) begin
      checks++; fails++;
      $display("FAIL in_ready timeout: got 0 expected 1");
    end
  endtask

  task automatic send(bit gaps);
    int n = msg.size(), nw = (msg.size() + 3) / 4;
    word_t w;
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 4; k++) w[31-8*k -: 8] = 4*i+k < n ? msg[4*i+k] : 8'($urandom);
      if (gaps) repeat ($urandom % 2) begin @(posedge clk); #1; end
      put_word(src(w), i == nw - 1, i == nw - 1 ? 2'(n % 4) : 2'd0);
    end
  endtask

  task automatic rand_msg(int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 512'(sb.size()), 512'd0);
  endtask

  function automatic exp_t abc_exp();
    exp_t e;
    e.d = '0;
    e.d[0] = 32'h6162_6380;
    e.d[15] = 32'h0000_0018;
    e.f = 1; e.l = 1;
    return e;
  endfunction

  always @(negedge clk)
    if (n_rst && blk_valid && blk_ready) begin
      if (sb.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected block: got %h expected none", blk_data);
      end else begin
        got = sb.pop_front();
        chk("blk_data", blk_data, got.d);
        chk("blk_first", 512'(blk_first), 512'(got.f));
        chk("blk_last", 512'(blk_last), 512'(got.l));
      end
    end

  initial forever begin
    @(posedge clk); #2;
    rnd_bit = ($urandom % 4) != 0;
  end

  initial begin
    int lens[6] = '{55, 56, 60, 63, 64, 119};
    exp_t e;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("rst_blk_data", blk_data, 512'd0);
    chk("rst_blk_first", 512'(blk_first), 512'd0);
    chk("rst_blk_last", 512'(blk_last), 512'd0);
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    n_rst = 1; ready_fix = 1;
    @(posedge clk); #1;
    sb.push_back(abc_exp());
    put_word(src({24'h616263, 8'($urandom)}), 1, 2'd3);
    drain();
    rand_msg(56); model(); send(0); drain();
    rand_msg(64); model(); send(0); drain();
    ready_fix = 0;
    e = abc_exp();
    sb.push_back(e);
    put_word(src(32'h6162_63aa), 1, 2'd3);
    for (int i = 0; i < 20 && !blk_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_blk_valid", 512'(blk_valid), 512'd1);
      chk("bp_in_ready", 512'(in_ready), 512'd0);
      chk("bp_blk_data", blk_data, e.d);
    end
    ready_fix = 1;
    drain();
    for (int i = 0; i < 7; i++) put_word($urandom, 0, 2'd0);
    n_rst = 0;
    #1;
    chk("mid_rst_blk_valid", 512'(blk_valid), 512'd0);
    chk("mid_rst_blk_data", blk_data, 512'd0);
    chk("mid_rst_blk_first", 512'(blk_first), 512'd0);
    chk("mid_rst_blk_last", 512'(blk_last), 512'd0);
    chk("mid_rst_in_ready", 512'(in_ready), 512'd1);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1;
    @(posedge clk); #1;
    sb.push_back(abc_exp());
    put_word(src(32'h6162_6300), 1, 2'd3);
    drain();
    rnd_ready = 1;
    foreach (lens[i]) begin rand_msg(lens[i]); model(); send(1); end
    for (int i = 0; i < 25; i++) begin rand_msg($urandom_range(1, 150)); model(); send(1); end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sha_msg_padder.md
SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by the shared package.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  reset, asynchronous and active-low; the block has one clock.
REQ-004 in_valid  input  1  in_data holds a message word.
REQ-005 in_ready  output  1  block accepts a word this cycle; a transfer is in_valid && in_ready.
REQ-006 in_data  input  32  message word, big-endian: byte0 in [31:24].
REQ-007 in_last  input  1  word is the final word of the message.
REQ-008 in_nbytes  input  2  valid bytes in the last word (0 = 4 bytes; 1..3 = bytes 0..n-1 valid); ignored unless in_last.
REQ-009 blk_valid  output  1  blk_data holds a complete 512-bit block.
REQ-010 blk_ready  input  1  consumer takes the block; a transfer is blk_valid && blk_ready.
REQ-011 blk_data  output  16x32  block, word 0 first, matching the compression core's data port.
REQ-012 blk_first  output  1  first block of a message; drives the core's clear, which loads the IV.
REQ-013 blk_last  output  1  final block of a message; the digest is valid after it is compressed.

Function
REQ-014 States SHALL be IDLE, FILL, PAD, LEN and EMIT; in_ready SHALL be 1 only in IDLE and FILL.
REQ-015 An accepted word SHALL be stored at the word index (0..15) and the 61-bit byte counter SHALL add 4, or in_nbytes when in_last and in_nbytes!=0.
REQ-016 Byte counter overflow SHALL wrap modulo 2^61 with no error.
REQ-017 When word 15 is accepted without in_last, the FSM SHALL go to EMIT; blk_valid SHALL rise the next cycle.
REQ-018 When in_last is accepted, the FSM SHALL go to PAD; blk_valid SHALL rise 2 cycles after the accept.
REQ-019 PAD, partial last word: invalid bytes SHALL be zeroed, 0x80 SHALL be written at byte position in_nbytes, and p = current index.
REQ-020 PAD, full last word: 0x80000000 SHALL be written at index p = current index + 1.
REQ-021 PAD with p = 16: the pad word SHALL be deferred to word 0 of the next block (pad_pending), and length SHALL be deferred (len_pending).
REQ-022 If p<=13, words 14/15 SHALL receive bitlen[63:32]/bitlen[31:0], where bitlen = bytes<<3; blk_last SHALL be 1.
REQ-023 If p is 14 or 15, length SHALL be deferred (len_pending) and blk_last SHALL be 0.
REQ-024 In EMIT, blk_data, blk_first and blk_last SHALL hold stable while blk_valid && !blk_ready.
REQ-025 A block handshake SHALL zero the buffer.
REQ-026 After the handshake, the FSM SHALL go to LEN if len_pending, to IDLE if blk_last, and to FILL otherwise.
REQ-027 LEN SHALL write the pad word (if pad_pending) and the length into the zeroed buffer, then enter EMIT with blk_last=1.
REQ-028 blk_first SHALL be 1 on the first block emitted after IDLE and 0 otherwise.
REQ-029 The minimum message is 1 byte; in_valid while in_ready=0 SHALL be held by the source.

Reset
REQ-030 On n_rst=0: state=IDLE, buffer=0, index=0, byte counter=0, pending flags=0.
REQ-031 Reset outputs: blk_valid=0, blk_data=0, blk_first=0, blk_last=0, in_ready=1 (in IDLE).
REQ-032 Reset mid-message or mid-EMIT SHALL discard all partial state; the first block after reset SHALL carry blk_first=1.

Configuration
REQ-033 With HM_PADDER_BSWAP_EN defined, in_data SHALL be byte-reversed on entry (little-endian source), and byte-position rules apply after the swap.
REQ-034 Without HM_PADDER_BSWAP_EN, in_data SHALL be stored unmodified.

Structure
REQ-035 Package hm_sha_pkg SHALL hold SHA_BLOCK_WORDS=16, SHA_LEN_WORD_HI=14, word_t (32-bit), block_t (16 x word_t) and the padder state enum.
REQ-036 One combinational sub-module, hm_sha_pad_word (last word + nbytes -> masked word with 0x80 inserted), SHALL be used.

Verification
REQ-037 Case "abc": 0x61626300 with last and nbytes=3 -> one block; w0=0x61626380, w1..w14=0, w15=0x00000018, first=last=1.
REQ-038 Case 56 bytes: 14 full words, last on word 13 -> block A: w14=0x80000000, w15=0, last=0; block B: all zero except w15=0x000001C0, last=1.
REQ-039 Case 64 bytes: 16 full words, last on word 15 -> block A is data with last=0; block B: w0=0x80000000, w15=0x00000200, first=0, last=1.
REQ-040 Case backpressure: blk_ready=0 for 5 cycles -> blk_data is unchanged, blk_valid=1 and in_ready=0 throughout; the transfer occurs on the 6th cycle.
REQ-041 Case reset: n_rst pulsed after 7 words -> all outputs are 0; a new "abc" message produces the REQ-037 block with blk_first=1.
REQ-042 Case HM_PADDER_BSWAP_EN defined: in_data=0x00636261 with last and nbytes=3 -> w0=0x61626380.
